// File: rtl/fifo_pkt_sequencer.sv
// Packet-boundary sequencer for the convertible FIFO: RECV -> CPU -> DRAIN hand-off,
// with a command/status register pair on the peripheral bus.
module fifo_pkt_sequencer #(
    parameter int unsigned CTRL_WIDTH = 8,
    parameter logic [63:0] CMD_ADDR   = 64'h10,
    parameter logic [63:0] STAT_ADDR  = 64'h11,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  fifo_empty,
    input  logic [63:0]           cpu_addr,
    input  logic [63:0]           cpu_din,
    input  logic                  cpu_wen,
    output logic [63:0]           cpu_dout,
    output logic [1:0]            mode,
    output logic                  in_block,
    output logic                  drain_start,
    output logic                  irq
);

    localparam int unsigned ST_W   = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned TMR_W  = 32;
    localparam int unsigned DATA_W = 64;

    localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] S_HDR   = 3'd1;
    localparam logic [ST_W-1:0] S_BODY  = 3'd2;
    localparam logic [ST_W-1:0] S_CPU   = 3'd3;
    localparam logic [ST_W-1:0] S_DRAIN = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT) - TMR_W'(1);

    logic [ST_W-1:0]   state_q,       state_d;
    logic [CNT_W-1:0]  word_cnt_q,    word_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q,     pkt_cnt_d;
    logic [CNT_W-1:0]  tmo_cnt_q,     tmo_cnt_d;
    logic [TMR_W-1:0]  tmr_q,         tmr_d;
    logic              err_q,         err_d;
    logic              drain_start_q, drain_start_d;
    logic [DATA_W-1:0] cpu_dout_q,    cpu_dout_d;

    logic              cmd_wr;
    logic              rel_req;
    logic              err_clr;
    logic              ctrl_nz;
    logic              tmo_hit;
    logic [CNT_W-1:0]  word_inc;
    logic [1:0]        state_code;
    logic              unused_din;

    assign unused_din = ^cpu_din[63:2];

    // Next-state, counters and status read data
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmr_d      = tmr_q;
        err_d      = err_q;

        cmd_wr   = cpu_wen && (cpu_addr == CMD_ADDR);
        rel_req  = cmd_wr && cpu_din[0];
        err_clr  = cmd_wr && cpu_din[1];
        ctrl_nz  = (in_ctrl != '0);
        tmo_hit  = (TIMEOUT != 0) && (tmr_q == TMR_LAST);
        word_inc = (word_cnt_q == CNT_MAX) ? word_cnt_q : word_cnt_q + CNT_W'(1);

        // Clear is applied first so a same-cycle error set overrides it
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_wr && ctrl_nz) begin
                    state_d    = S_HDR;
                    word_cnt_d = CNT_W'(1);
                end
            end
            S_HDR: begin
                if (in_wr) begin
                    word_cnt_d = word_inc;
                    if (!ctrl_nz) begin
                        state_d = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (in_wr) begin
                    word_cnt_d = word_inc;
                    if (ctrl_nz) begin
                        state_d = S_CPU;
                        tmr_d   = '0;
                    end
                end
            end
            S_CPU: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (in_wr) begin
                    err_d = 1'b1;
                end
                if (rel_req) begin
                    state_d = S_DRAIN;
                end else if (tmo_hit) begin
                    state_d   = S_DRAIN;
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (in_wr) begin
                    err_d = 1'b1;
                end
                // drain_start_q marks the first DRAIN cycle, where empty is not yet trusted
                if (!drain_start_q && fifo_empty) begin
                    state_d   = S_IDLE;
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        drain_start_d = (state_d == S_DRAIN) && (state_q != S_DRAIN);

        case (state_q)
            S_CPU:   state_code = 2'd1;
            S_DRAIN: state_code = 2'd2;
            default: state_code = 2'd0;
        endcase

        cpu_dout_d = (cpu_addr == STAT_ADDR)
                   ? {state_code, err_q, 13'd0, pkt_cnt_q, tmo_cnt_q, word_cnt_q}
                   : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            pkt_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            tmr_q         <= '0;
            err_q         <= 1'b0;
            drain_start_q <= 1'b0;
            cpu_dout_q    <= '0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            pkt_cnt_q     <= pkt_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tmr_q         <= tmr_d;
            err_q         <= err_d;
            drain_start_q <= drain_start_d;
            cpu_dout_q    <= cpu_dout_d;
        end
    end

    assign mode        = (state_q == S_CPU)   ? 2'd1 :
                         (state_q == S_DRAIN) ? 2'd2 : 2'd0;
    assign in_block    = (state_q == S_CPU) || (state_q == S_DRAIN);
    assign irq         = (state_q == S_CPU);
    assign drain_start = drain_start_q;
    assign cpu_dout    = cpu_dout_q;

endmodule

// File: tb/tb_fifo_pkt_sequencer.sv
// Directed bench for fifo_pkt_sequencer; stimulus pushes expectations, a negedge monitor checks them.
module tb_fifo_pkt_sequencer;

    localparam logic [63:0] CMD_ADDR  = 64'h10;
    localparam logic [63:0] STAT_ADDR = 64'h11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_wr;
    logic [7:0]  in_ctrl;
    logic        fifo_empty;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_din;
    logic        cpu_wen;
    logic [63:0] cpu_dout;
    logic [1:0]  mode;
    logic        in_block;
    logic        drain_start;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        int          at_cyc;
        bit          is_rd;
        logic [63:0] dout;
        logic [1:0]  mode;
        logic        blk;
        logic        irq;
        logic        ds;
    } sb_t;

    sb_t sb_q[$];

    fifo_pkt_sequencer #(
        .CTRL_WIDTH(8),
        .CMD_ADDR  (CMD_ADDR),
        .STAT_ADDR (STAT_ADDR),
        .TIMEOUT   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_wr      (in_wr),
        .in_ctrl    (in_ctrl),
        .fifo_empty (fifo_empty),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_wen    (cpu_wen),
        .cpu_dout   (cpu_dout),
        .mode       (mode),
        .in_block   (in_block),
        .drain_start(drain_start),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at_cyc <= cyc) begin
                checks = checks + 1;
                if (sb_q[i].at_cyc < cyc) begin
                    errors = errors + 1;
                    $display("FAIL %s: check missed its cycle %0d (now %0d)", sb_q[i].name, sb_q[i].at_cyc, cyc);
                end else if (sb_q[i].is_rd) begin
                    if (cpu_dout !== sb_q[i].dout) begin
                        errors = errors + 1;
                        $display("FAIL %s: cpu_dout got %h expected %h", sb_q[i].name, cpu_dout, sb_q[i].dout);
                    end
                end else begin
                    if ({mode, in_block, irq, drain_start} !==
                        {sb_q[i].mode, sb_q[i].blk, sb_q[i].irq, sb_q[i].ds}) begin
                        errors = errors + 1;
                        $display("FAIL %s: mode/blk/irq/ds got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                                 sb_q[i].name, mode, in_block, irq, drain_start,
                                 sb_q[i].mode, sb_q[i].blk, sb_q[i].irq, sb_q[i].ds);
                    end
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_wr    = 1'b0;
        cpu_wen  = 1'b0;
        cpu_addr = 64'h0;
        cpu_din  = 64'h0;
    endtask

    task automatic push_out(input string n, input logic [1:0] m, input logic b,
                            input logic i, input logic d);
        sb_t e;
        e.name = n; e.at_cyc = cyc; e.is_rd = 1'b0; e.dout = 64'h0;
        e.mode = m; e.blk = b; e.irq = i; e.ds = d;
        sb_q.push_back(e);
    endtask

    task automatic push_rd(input string n, input logic [63:0] exp, input int at);
        sb_t e;
        e.name = n; e.at_cyc = at; e.is_rd = 1'b1; e.dout = exp;
        e.mode = 2'd0; e.blk = 1'b0; e.irq = 1'b0; e.ds = 1'b0;
        sb_q.push_back(e);
    endtask

    // Status read issued this cycle; data expected on the following cycle
    task automatic read_now(input string n, input logic [63:0] exp);
        cpu_addr = STAT_ADDR;
        push_rd(n, exp, cyc + 1);
    endtask

    task automatic cmd(input logic [63:0] d);
        cpu_wen  = 1'b1;
        cpu_addr = CMD_ADDR;
        cpu_din  = d;
    endtask

    task automatic word(input logic [7:0] c);
        in_wr   = 1'b1;
        in_ctrl = c;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_wr      = 1'b1;
        in_ctrl    = 8'hFF;
        fifo_empty = 1'b0;
        cpu_addr   = STAT_ADDR;
        cpu_din    = 64'h0;
        cpu_wen    = 1'b0;

        // Reset with input activity held
        step();
        push_out("rst_out", 2'd0, 1'b0, 1'b0, 1'b0);
        push_rd("rst_dout", 64'h0, cyc);
        rst = 1'b0;
        read_now("rst_stat", 64'h0);
        step();

        // Error set/clear in CPU, then reset mid-DRAIN
        word(8'hFF); word(8'h00); word(8'h10);
        push_out("err_cpu", 2'd1, 1'b1, 1'b1, 1'b0);
        in_wr = 1'b1; in_ctrl = 8'h00;
        step();
        read_now("err_set", 64'h6000_0000_0000_0003);
        step();
        cmd(64'h2);
        step();
        read_now("err_clr", 64'h4000_0000_0000_0003);
        step();
        cmd(64'h1);
        fifo_empty = 1'b1;
        step();
        push_out("err_drain", 2'd2, 1'b1, 1'b0, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        push_out("rst_drain_out", 2'd0, 1'b0, 1'b0, 1'b0);
        read_now("rst_drain_stat", 64'h0);
        step();
        fifo_empty = 1'b0;

        // Release outside CPU is ignored; full packet then CPU release
        cmd(64'h1);
        step();
        push_out("rel_ignored", 2'd0, 1'b0, 1'b0, 1'b0);
        word(8'hFF); word(8'h00); word(8'h00);
        push_out("mid_pkt", 2'd0, 1'b0, 1'b0, 1'b0);
        word(8'h00); word(8'h10);
        push_out("pkt_cpu", 2'd1, 1'b1, 1'b1, 1'b0);
        read_now("pkt_stat", 64'h4000_0000_0000_0005);
        step();
        cmd(64'h1);
        step();
        push_out("rel_d0", 2'd2, 1'b1, 1'b0, 1'b1);
        step();
        push_out("rel_d1", 2'd2, 1'b1, 1'b0, 1'b0);
        read_now("rel_dstat", 64'h8000_0000_0000_0005);
        step();
        step();
        step();
        fifo_empty = 1'b1;
        push_out("rel_d4", 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        fifo_empty = 1'b0;
        push_out("rel_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        read_now("rel_stat", 64'h0000_0001_0000_0005);
        step();

        // Timeout with no release
        word(8'hFF); word(8'h00); word(8'h10);
        repeat (7) step();
        push_out("tmo_c7", 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        push_out("tmo_d0", 2'd2, 1'b1, 1'b0, 1'b1);
        fifo_empty = 1'b1;
        step();
        push_out("tmo_d1", 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        push_out("tmo_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        read_now("tmo_stat", 64'h0000_0002_0001_0003);
        step();

        // Release coincides with timeout; empty already high gives earliest exit
        word(8'hFF); word(8'hFF); word(8'h00); word(8'h00); word(8'h10);
        repeat (7) step();
        cmd(64'h1);
        push_out("sim_c7", 2'd1, 1'b1, 1'b1, 1'b0);
        step();
        push_out("sim_d0", 2'd2, 1'b1, 1'b0, 1'b1);
        step();
        push_out("sim_d1", 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        push_out("sim_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        read_now("sim_stat", 64'h0000_0003_0001_0005);
        step();
        fifo_empty = 1'b0;
        step();
        step();

        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain_queue: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
